// File: rtl/alu_control_pipe.sv
// MIPS ALU-control decoder behind a DEPTH-stage valid/ready pipe, with a busy lockout after mult/div.
// Define ALUCTL_ILLEGAL_EN to decode unsupported codes as 1111 and raise illegal; otherwise they map to add.
module alu_control_pipe #(
  parameter int DEPTH     = 1,
  parameter int FUNC_W    = 4,
  parameter int MD_CYCLES = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instruction,
  input  logic [1:0]        alu_op,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [FUNC_W-1:0] func_out,
  output logic              illegal,
  output logic              md_busy
);

  localparam logic [7:0] MD_LOAD = 8'(MD_CYCLES);
`ifdef ALUCTL_ILLEGAL_EN
  localparam logic [3:0] F_UNK = 4'b1111;
`else
  localparam logic [3:0] F_UNK = 4'b0010;
`endif

  function automatic logic [3:0] decode(input logic [1:0] op, input logic [31:0] ins);
    logic [3:0] f;
    f = F_UNK;
    case (op)
      2'b00: f = 4'b0010;
      2'b01: f = 4'b0110;
      2'b10: begin
        case (ins[5:0])
          6'b100000: f = 4'b0010;
          6'b100010: f = 4'b0110;
          6'b100100: f = 4'b0000;
          6'b100101: f = 4'b0001;
          6'b101010: f = 4'b0111;
          6'b100111: f = 4'b1100;
          6'b011000: f = 4'b1000;
          6'b011010: f = 4'b1001;
          default:   f = F_UNK;
        endcase
      end
      2'b11: begin
        case (ins[31:26])
          6'b001000: f = 4'b0010;
          6'b001100: f = 4'b0000;
          6'b001101: f = 4'b0001;
          6'b001010: f = 4'b0111;
          default:   f = F_UNK;
        endcase
      end
      default: f = F_UNK;
    endcase
    return f;
  endfunction

  logic [DEPTH-1:0] r_v;
  logic [3:0]       r_f [DEPTH];
  logic [DEPTH-1:0] w_go;
  logic             w_free0;
  logic             w_in_xfer;
  logic [3:0]       w_dec;
  logic             w_is_md;
  logic [7:0]       r_md_cnt;
  logic [7:0]       w_md_cnt_nxt;
  logic             r_md_busy;

  // A stage moves forward when everything ahead of it can make room this cycle.
  always_comb begin
    logic v_free;
    v_free = out_ready;
    w_go   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      w_go[i] = r_v[i] && v_free;
      v_free  = !r_v[i] || v_free;
    end
    w_free0 = v_free;
  end

  assign w_dec     = decode(alu_op, instruction);
  assign w_is_md   = (w_dec == 4'b1000) || (w_dec == 4'b1001);
  assign in_ready  = rst_n && !r_md_busy && w_free0;
  assign w_in_xfer = in_valid && in_ready;

  // Busy countdown: loaded on mult/div acceptance, runs to zero.
  always_comb begin
    w_md_cnt_nxt = 8'd0;
    if (w_in_xfer && w_is_md) begin
      w_md_cnt_nxt = MD_LOAD;
    end else if (r_md_cnt != 8'd0) begin
      w_md_cnt_nxt = r_md_cnt - 8'd1;
    end else begin
      w_md_cnt_nxt = 8'd0;
    end
  end

  // Busy counter and flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_md_cnt  <= 8'd0;
      r_md_busy <= 1'b0;
    end else begin
      r_md_cnt  <= w_md_cnt_nxt;
      r_md_busy <= (w_md_cnt_nxt != 8'd0);
    end
  end

  // Decode pipe: each stage loads from behind or empties when it moves on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_f[i] <= 4'd0;
      end
    end else begin
      if (w_in_xfer) begin
        r_v[0] <= 1'b1;
        r_f[0] <= w_dec;
      end else if (w_go[0]) begin
        r_v[0] <= 1'b0;
      end
      for (int i = 1; i < DEPTH; i++) begin
        if (w_go[i-1]) begin
          r_v[i] <= 1'b1;
          r_f[i] <= r_f[i-1];
        end else if (w_go[i]) begin
          r_v[i] <= 1'b0;
        end
      end
    end
  end

  assign out_valid = r_v[DEPTH-1];
  assign func_out  = FUNC_W'(r_f[DEPTH-1]);
  assign md_busy   = r_md_busy;
`ifdef ALUCTL_ILLEGAL_EN
  assign illegal   = (r_f[DEPTH-1] == 4'b1111);
`else
  assign illegal   = 1'b0;
`endif

endmodule

// File: tb/tb_alu_control_pipe.sv
// Bench for alu_control_pipe: directed scenarios plus random traffic against a transaction-level model.
module tb_alu_control_pipe;
  localparam int D = 3;
  localparam int M = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instruction;
  logic [1:0]  alu_op;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  func_out;
  logic        illegal;
  logic        md_busy;

  always #5 clk = ~clk;

  alu_control_pipe #(.DEPTH(D), .FUNC_W(4), .MD_CYCLES(M)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .instruction(instruction), .alu_op(alu_op), .out_valid(out_valid),
    .out_ready(out_ready), .func_out(func_out), .illegal(illegal), .md_busy(md_busy)
  );

  typedef struct {
    logic [4:0] exp;
    int         acc;
  } ent_t;

  ent_t q[$];
  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int busy_end = -1;
  int last_out = -1;

  logic [5:0] fn_tab [8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h27, 6'h18, 6'h1A};
  logic [5:0] op_tab [4] = '{6'h08, 6'h0C, 6'h0D, 6'h0A};

  // Reference decode straight from the ALU-control table: returns {illegal, func}.
  function automatic logic [4:0] ref_decode(input logic [1:0] op, input logic [31:0] ins);
    logic [4:0] unk;
`ifdef ALUCTL_ILLEGAL_EN
    unk = 5'b11111;
`else
    unk = 5'b00010;
`endif
    if (op == 2'b00) return 5'b00010;
    if (op == 2'b01) return 5'b00110;
    if (op == 2'b10) begin
      case (ins[5:0])
        6'h20: return 5'b00010;
        6'h22: return 5'b00110;
        6'h24: return 5'b00000;
        6'h25: return 5'b00001;
        6'h2A: return 5'b00111;
        6'h27: return 5'b01100;
        6'h18: return 5'b01000;
        6'h1A: return 5'b01001;
        default: return unk;
      endcase
    end
    case (ins[31:26])
      6'h08: return 5'b00010;
      6'h0C: return 5'b00000;
      6'h0D: return 5'b00001;
      6'h0A: return 5'b00111;
      default: return unk;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic rst_chk(input string tag);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_func_out"},  32'(func_out),  32'd0);
    chk({tag, "_illegal"},   32'(illegal),   32'd0);
    chk({tag, "_md_busy"},   32'(md_busy),   32'd0);
    chk({tag, "_in_ready"},  32'(in_ready),  32'd0);
  endtask

  // One clock cycle: drive inputs, compare against the model, then advance the model.
  task automatic cycle(input logic v, input logic [1:0] op, input logic [31:0] ins, input logic ordy);
    int   vis;
    logic ov, be, dr, ir;
    ent_t e;
    @(negedge clk);
    in_valid = v; alu_op = op; instruction = ins; out_ready = ordy;
    #1;
    ov = 1'b0;
    if (q.size() > 0) begin
      vis = q[0].acc + D;
      if (last_out + 1 > vis) vis = last_out + 1;
      ov = (vis <= cyc);
    end
    chk("out_valid", 32'(out_valid), 32'(ov));
    if (ov) begin
      chk("func_out", 32'(func_out), 32'(q[0].exp[3:0]));
      chk("illegal",  32'(illegal),  32'(q[0].exp[4]));
    end
    be = (cyc <= busy_end);
    chk("md_busy", 32'(md_busy), 32'(be));
    dr = ov && ordy;
    ir = !be && ((q.size() - (dr ? 1 : 0)) < D);
    chk("in_ready", 32'(in_ready), 32'(ir));
    if (dr) begin
      last_out = cyc;
      void'(q.pop_front());
    end
    if (v && ir) begin
      e.exp = ref_decode(op, ins);
      e.acc = cyc;
      q.push_back(e);
      if (op == 2'b10 && (ins[5:0] == 6'h18 || ins[5:0] == 6'h1A)) busy_end = cyc + M;
    end
    @(posedge clk);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 2'b00, 32'd0, 1'b1);
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic reset_pulse();
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1 rst_chk("pulse");
    #1 rst_n = 1'b1;
    q.delete();
    busy_end = -1;
    @(posedge clk);
    cyc++;
    #1 chk("in_ready_post_pulse", 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] ins;
    logic [1:0]  op;
    rst_n = 1'b0; in_valid = 1'b1; alu_op = 2'b10; instruction = 32'h0000_0018; out_ready = 1'b1;
    #1 rst_chk("rst0");
    repeat (3) @(negedge clk);
    #1 rst_chk("rst_held");
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0;
    #1 chk("in_ready_after_rst", 32'(in_ready), 32'd1);

    // add then sub, no backpressure
    cycle(1'b1, 2'b10, 32'h0000_0020, 1'b1);
    cycle(1'b1, 2'b10, 32'h0000_0022, 1'b1);
    idle(5);

    // stall output while three ops fill the pipe, a fourth waits
    cycle(1'b1, 2'b10, 32'h0000_0024, 1'b0);
    cycle(1'b1, 2'b10, 32'h0000_0025, 1'b0);
    cycle(1'b1, 2'b10, 32'h0000_002A, 1'b0);
    cycle(1'b1, 2'b10, 32'h0000_0020, 1'b0);
    cycle(1'b1, 2'b10, 32'h0000_0020, 1'b0);
    cycle(1'b1, 2'b10, 32'h0000_0020, 1'b1);
    idle(6);

    // mult busy window with a held follower
    cycle(1'b1, 2'b10, 32'h0000_0018, 1'b1);
    for (int i = 0; i < 6; i++) cycle(1'b1, 2'b10, 32'h0000_0022, 1'b1);
    idle(5);

    // immediate ops, fixed classes, unknown codes
    cycle(1'b1, 2'b11, 32'h3400_0000, 1'b1);
    cycle(1'b1, 2'b11, 32'hFC00_0000, 1'b1);
    cycle(1'b1, 2'b00, 32'h8C00_0000, 1'b1);
    cycle(1'b1, 2'b01, 32'h1000_0000, 1'b1);
    cycle(1'b1, 2'b11, 32'h2000_0000, 1'b1);
    cycle(1'b1, 2'b11, 32'h3000_0000, 1'b1);
    cycle(1'b1, 2'b11, 32'h2800_0000, 1'b1);
    cycle(1'b1, 2'b10, 32'h0000_0027, 1'b1);
    cycle(1'b1, 2'b10, 32'h0000_003F, 1'b1);
    idle(5);

    // div with two entries in flight, then reset mid-count
    cycle(1'b1, 2'b10, 32'h0000_0020, 1'b0);
    cycle(1'b1, 2'b10, 32'h0000_001A, 1'b0);
    cycle(1'b0, 2'b00, 32'd0, 1'b0);
    reset_pulse();
    idle(3);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      op  = 2'($urandom_range(0, 3));
      ins = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        ins[5:0]   = fn_tab[$urandom_range(0, 7)];
        ins[31:26] = op_tab[$urandom_range(0, 3)];
      end
      if (i == 1500) reset_pulse();
      cycle($urandom_range(0, 3) != 0, op, ins, $urandom_range(0, 3) != 0);
    end
    idle(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/alu_control_pipe.md
ALU_CONTROL_PIPE -- requirements
Module: alu_control_pipe

Interface
REQ-001 Parameter DEPTH, default 1: number of registered decode stages, legal range 1..4.
REQ-002 Parameter FUNC_W, default 4: width of func_out, minimum 4.
REQ-003 Parameter MD_CYCLES, default 8: busy duration, in cycles, of a multiply/divide op, legal range 2..255.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 in_valid  input  1  instruction/alu_op presented.
REQ-007 in_ready  output  1  block accepts input this cycle.
REQ-008 instruction  input  32  MIPS instruction word.
REQ-009 alu_op  input  2  main-control ALU operation class.
REQ-010 out_valid  output  1  func_out/illegal valid.
REQ-011 out_ready  input  1  downstream accepts output.
REQ-012 func_out  output  FUNC_W  ALU function code, zero-extended from 4 bits.
REQ-013 illegal  output  1  decoded op unsupported; qualified by out_valid.
REQ-014 md_busy  output  1  multi-cycle multiply/divide in progress.

Function
REQ-015 Decode, alu_op 00 (lw/sw) SHALL give 0010 (add); 01 (beq/bne) SHALL give 0110 (sub).
REQ-016 Decode, alu_op 10 on funct[5:0]: 100000->0010, 100010->0110, 100100->0000, 100101->0001, 101010->0111, 100111->1100, 011000 (mult)->1000, 011010 (div)->1001.
REQ-017 Decode, alu_op 11 on opcode[31:26]: 001000->0010, 001100->0000, 001101->0001, 001010->0111.
REQ-018 Any other funct/opcode SHALL be handled per REQ-032/REQ-033.
REQ-019 Transfer in occurs when in_valid && in_ready; transfer out when out_valid && out_ready.
REQ-020 Latency SHALL be exactly DEPTH cycles from input transfer to out_valid with no backpressure.
REQ-021 Each stage holds one entry; stage advances when the next stage is empty or draining the same cycle.
REQ-022 out_valid && !out_ready SHALL hold func_out and illegal stable until transfer.
REQ-023 in_ready = !md_busy && (stage 1 empty || stage 1 advances this cycle); with full backpressure throughput SHALL resume at 1/cycle, no bubbles, no loss, no duplication.
REQ-024 Accepting mult or div SHALL load the busy counter with MD_CYCLES; md_busy asserts the following cycle.
REQ-025 md_busy SHALL stay high for exactly MD_CYCLES cycles, decrementing each cycle; it deasserts when the counter reaches 0, and in_ready may rise that same cycle.
REQ-026 The mult/div entry itself SHALL flow through the pipe normally; md_busy only blocks new input.
REQ-027 in_valid while in_ready=0 SHALL be ignored; the source must hold.

Reset
REQ-028 rst_n low SHALL immediately clear all stage valids, out_valid, func_out (0), illegal (0), md_busy (0) and the busy counter (0).
REQ-029 Reset mid-operation SHALL discard all in-flight entries and any busy count.
REQ-030 in_ready SHALL be 0 during reset and 1 on the first cycle after rst_n rises.
REQ-031 No output change may depend on any clk edge while rst_n is low.

Configuration
REQ-032 With ALUCTL_ILLEGAL_EN defined: unknown codes SHALL give func_out 1111 with illegal=1.
REQ-033 Without ALUCTL_ILLEGAL_EN: unknown codes SHALL give 0010 (add); illegal is tied to 0 and no illegal logic is built.

Verification
REQ-034 DEPTH=1, out_ready=1, alu_op=10, instr 0x00000020 then 0x00000022 -> func_out 0010 then 0110, each one cycle after acceptance.
REQ-035 DEPTH=3, out_ready=0 for 5 cycles, three back-to-back ops (and 0x24, or 0x25, slt 0x2A) -> in_ready drops after the pipe fills; on release 0000, 0001, 0111 stream on consecutive cycles.
REQ-036 MD_CYCLES=4, alu_op=10 instr 0x00000018 -> func_out 1000; md_busy high 4 cycles; in_ready low over the same 4 cycles; next op accepted on the cycle md_busy falls.
REQ-037 alu_op=11, opcode 001101 -> 0001; opcode 111111 -> 1111 with illegal=1 (macro defined), or 0010 with illegal=0 (macro undefined).
REQ-038 rst_n pulsed low between clock edges during a div busy count with 2 entries in flight -> out_valid, md_busy and func_out go 0 immediately; in_ready=1 on the first edge after release.
